// File: rtl/reg_write_arbiter.sv
// Two-requester register-file write arbiter with a single-entry output stage.
// Round-robin on ties; writes to x0 are consumed but never issued.
//
// state | meaning
// EMPTY | output stage holds no write (wr_valid=0)
// FULL  | output stage holds a write for the register bank (wr_valid=1)
module reg_write_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic              last_grant
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stageState_t;

    stageState_t       stageState;
    logic              canAccept;
    logic              grant0;
    logic              grant1;
    logic              anyGrant;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;

    // Accept when the stage is free now or drains on this same edge.
    always_comb begin
        canAccept = rst && ((stageState == EMPTY) || wr_ready);
        grant0    = canAccept && req0_valid && (!req1_valid || last_grant);
        grant1    = canAccept && req1_valid && (!req0_valid || !last_grant);
        anyGrant  = grant0 || grant1;
        selAddr   = grant1 ? req1_addr : req0_addr;
        selData   = grant1 ? req1_data : req0_data;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign wr_valid   = (stageState == FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stageState <= EMPTY;
            wr_addr    <= '0;
            wr_data    <= '0;
            last_grant <= 1'b1;
        end else begin
            if (anyGrant) begin
                last_grant <= grant1;
            end
            if (anyGrant && (selAddr != '0)) begin
                stageState <= FULL;
                wr_addr    <= selAddr;
                wr_data    <= selData;
            end else if ((stageState == FULL) && wr_ready) begin
                stageState <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: expected writes are queued as
// requests are driven and popped when the output stage hands a write off.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0;
    logic [4:0]  req0_addr = '0;
    logic [31:0] req0_data = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [4:0]  req1_addr = '0;
    logic [31:0] req1_data = '0;
    logic        req1_ready;
    logic        wr_valid;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready = 1'b0;
    logic        last_grant;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wrExp_t;

    wrExp_t expQ[$];
    int     numChecks = 0;
    int     numErrors = 0;

    reg_write_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .last_grant (last_grant)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [4:0] a, input logic [31:0] d);
        wrExp_t e;
        e.a = a;
        e.d = d;
        expQ.push_back(e);
    endtask

    task automatic doReset();
        rst        = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        wr_ready   = 1'b0;
        @(negedge clk);
        checkVal("rst_wr_valid", wr_valid, 0);
        checkVal("rst_wr_addr", wr_addr, 0);
        checkVal("rst_wr_data", wr_data, 0);
        checkVal("rst_last_grant", last_grant, 1);
        checkVal("rst_req1_ready", req1_ready, 0);
        req1_valid = 1'b0;
        nextCycle();
        rst = 1'b1;
    endtask

    // Every handshake on the write side must match the oldest expected write.
    always @(negedge clk) begin : monitor
        wrExp_t e;
        if (rst && wr_valid && wr_ready) begin
            if (expQ.size() == 0) begin
                checkVal("unexpected_wr", {27'd0, wr_addr}, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkVal("wr_addr", {27'd0, wr_addr}, {27'd0, e.a});
                checkVal("wr_data", wr_data, e.d);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int g0;
        int g1;
        #1;
        doReset();

        // Single request, one-cycle latency
        req0_valid = 1; req0_addr = 5; req0_data = 32'hDEADBEEF; wr_ready = 1;
        @(negedge clk);
        checkVal("single_r0_ready", req0_ready, 1);
        checkVal("single_r1_ready", req1_ready, 0);
        checkVal("single_wv0", wr_valid, 0);
        pushExp(5, 32'hDEADBEEF);
        nextCycle();
        req0_valid = 0;
        @(negedge clk);
        checkVal("single_wv1", wr_valid, 1);
        checkVal("single_lg", last_grant, 0);
        nextCycle();
        @(negedge clk);
        checkVal("single_wv2", wr_valid, 0);
        nextCycle();

        // Tie after reset: requester 0 first, then 1
        doReset();
        req0_valid = 1; req0_addr = 1; req0_data = 32'h11;
        req1_valid = 1; req1_addr = 2; req1_data = 32'h22; wr_ready = 1;
        @(negedge clk);
        checkVal("tie_r0_ready", req0_ready, 1);
        checkVal("tie_r1_ready0", req1_ready, 0);
        pushExp(1, 32'h11);
        nextCycle();
        @(negedge clk);
        checkVal("tie_r1_ready1", req1_ready, 1);
        checkVal("tie_r0_ready1", req0_ready, 0);
        checkVal("tie_lg0", last_grant, 0);
        pushExp(2, 32'h22);
        nextCycle();
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        checkVal("tie_wv", wr_valid, 1);
        checkVal("tie_lg1", last_grant, 1);
        nextCycle();

        // Backpressure with a waiting requester whose data wobbles
        req0_valid = 1; req0_addr = 7; req0_data = 32'hA5A5A5A5;
        @(negedge clk);
        checkVal("bp_r0_ready", req0_ready, 1);
        pushExp(7, 32'hA5A5A5A5);
        nextCycle();
        req0_valid = 0; req1_valid = 1; req1_addr = 3; wr_ready = 0;
        for (int i = 0; i < 4; i++) begin
            req1_data = (i == 3) ? 32'h33 : 32'hBAD0_0000 + i;
            @(negedge clk);
            checkVal("bp_wv", wr_valid, 1);
            checkVal("bp_waddr", {27'd0, wr_addr}, 7);
            checkVal("bp_wdata", wr_data, 32'hA5A5A5A5);
            checkVal("bp_r1_ready", req1_ready, 0);
            nextCycle();
        end
        wr_ready = 1;
        @(negedge clk);
        checkVal("bp_r1_accept", req1_ready, 1);
        pushExp(3, 32'h33);
        nextCycle();
        req1_valid = 0;
        @(negedge clk);
        checkVal("bp_nobubble", wr_valid, 1);
        nextCycle();
        @(negedge clk);
        checkVal("bp_drain", wr_valid, 0);
        nextCycle();

        // x0 drop: consumed, no write, grant still recorded
        req0_valid = 1; req0_addr = 4; req0_data = 32'h44;
        @(negedge clk);
        checkVal("x0_pre_r0", req0_ready, 1);
        pushExp(4, 32'h44);
        nextCycle();
        req0_valid = 0; req1_valid = 1; req1_addr = 0; req1_data = 32'hFFFFFFFF;
        @(negedge clk);
        checkVal("x0_r1_ready", req1_ready, 1);
        checkVal("x0_lg_before", last_grant, 0);
        nextCycle();
        req1_valid = 0;
        @(negedge clk);
        checkVal("x0_wv", wr_valid, 0);
        checkVal("x0_lg", last_grant, 1);
        nextCycle();

        // Async reset while FULL discards the held write
        req0_valid = 1; req0_addr = 9; req0_data = 32'h99; wr_ready = 0;
        @(negedge clk);
        checkVal("ar_r0_ready", req0_ready, 1);
        nextCycle();
        req0_valid = 0;
        checkVal("ar_full", wr_valid, 1);
        #2;
        rst = 0;
        #1;
        checkVal("ar_wv", wr_valid, 0);
        checkVal("ar_waddr", {27'd0, wr_addr}, 0);
        checkVal("ar_lg", last_grant, 1);
        nextCycle();
        rst = 1; wr_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkVal("ar_after_wv", wr_valid, 0);
            nextCycle();
        end

        // Fairness: both valid for 20 cycles
        doReset();
        g0 = 0; g1 = 0;
        req0_valid = 1; req1_valid = 1; wr_ready = 1;
        req0_addr = 10; req1_addr = 20;
        for (int k = 0; k < 20; k++) begin
            req0_data = 32'h1000 + k;
            req1_data = 32'h2000 + k;
            @(negedge clk);
            checkVal("fair_r0", req0_ready, (k % 2 == 0) ? 1 : 0);
            checkVal("fair_r1", req1_ready, (k % 2 == 1) ? 1 : 0);
            if (req0_ready) g0++;
            if (req1_ready) g1++;
            if (k % 2 == 0) pushExp(10, 32'h1000 + k);
            else            pushExp(20, 32'h2000 + k);
            nextCycle();
        end
        req0_valid = 0; req1_valid = 0;
        checkVal("fair_cnt0", g0, 10);
        checkVal("fair_cnt1", g1, 10);

        for (int i = 0; i < 10 && expQ.size() != 0; i++) nextCycle();
        checkVal("drain_queue", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
        $finish;
    end

endmodule
